// File: rtl/fifo_rd_arb_pkg.sv
// Shared definitions for the async-FIFO read-port arbiter: FSM encoding,
// burst counter sizing and the starvation threshold.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT = 16;

  // Counter holds 0..burst_max-1; keep at least one bit for burst_max=1.
  function automatic int unsigned burst_cnt_w(input int unsigned burst_max);
    return (burst_max > 1) ? $clog2(burst_max) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping past NUM_REQ-1 back to 0.
module rr_picker
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       pick_valid
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // rr_ptr and i are both below NUM_REQ, so one subtraction wraps it.
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      cand = sum[IW-1:0];
      if (!pick_valid && req[cand]) begin
        pick[cand] = 1'b1;
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ consumers.
// Optional statistics outputs (word_cnt, starve) under FIFO_RD_ARB_STATS_EN.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       rempty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rinc,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  output logic [$clog2(NUM_REQ)-1:0] dout_id
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [15:0]                word_cnt,
  output logic [NUM_REQ-1:0]         starve
`endif
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned BW = burst_cnt_w(BURST_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

  arb_state_e         state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      rr_ptr;
  logic [BW-1:0]      burst_cnt;
  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               owner_req;
  logic               release_now;
  logic               rinc_d;
  logic [IW-1:0]      id_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // grant is zero outside GRANT, so this also keeps rinc low while idle.
  always_comb begin
    owner_req   = |(grant & req);
    rinc        = owner_req && !rempty;
    release_now = (state == GRANT) &&
                  (!owner_req || rempty || (rinc && (burst_cnt == BURST_LAST)));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !rempty) begin
            state     <= GRANT;
            grant     <= pick;
            owner     <= pick_idx;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end else if (rinc) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO presents rdata the cycle after rinc; capture it one cycle later.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rinc_d     <= 1'b0;
      id_d       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_id    <= '0;
    end else begin
      rinc_d     <= rinc;
      id_d       <= owner;
      dout_valid <= rinc_d;
      if (rinc_d) begin
        dout    <= rdata;
        dout_id <= id_d;
      end
    end
  end

`ifdef FIFO_RD_ARB_STATS_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt [NUM_REQ];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      word_cnt <= '0;
      starve   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        starve_cnt[i] <= '0;
      end
    end else begin
      word_cnt <= word_cnt + 16'(dout_valid);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          starve_cnt[i] <= '0;
          starve[i]     <= 1'b0;
        end else if (req[i]) begin
          // Saturating wait counter; flag is sticky until the next grant.
          if (starve_cnt[i] != STARVE_MAX) begin
            starve_cnt[i] <= starve_cnt[i] + 1'b1;
          end
          if (starve_cnt[i] == STARVE_MAX - 1'b1) begin
            starve[i] <= 1'b1;
          end
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter with a behavioural FIFO read side
// and a scoreboard of expected (owner, data) words in FIFO write order.
module tb_fifo_rd_arbiter;

  logic       rclk;
  logic       rrst_n;
  logic [3:0] req;
  logic       rempty = 1'b1;
  logic [7:0] rdata  = '0;
  logic       rinc;
  logic [3:0] grant;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] dout_id;
`ifdef FIFO_RD_ARB_STATS_EN
  logic [15:0] word_cnt;
  logic [3:0]  starve;
`endif

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    bit         chk_id;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] fifo_q[$];
  exp_t       e;
  bit         sb_en = 1'b1;
  int         n_tests = 0;
  int         n_fail  = 0;

  fifo_rd_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .BURST_MAX  (4)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .req        (req),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .grant      (grant),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_id    (dout_id)
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    .word_cnt   (word_cnt),
    .starve     (starve)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // FIFO read side: rdata appears the cycle after rinc; writes land at the edge.
  always @(posedge rclk) begin
    if (rinc === 1'b1 && fifo_q.size() > 0) rdata <= fifo_q.pop_front();
    while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    rempty <= (fifo_q.size() == 0);
  end

  always @(negedge rclk) begin
    if (rrst_n === 1'b1) begin
      if (rinc === 1'b1) begin
        n_tests++;
        if (rempty !== 1'b0 || !$onehot(grant) || (grant & req) == 4'b0) begin
          n_fail++;
          $display("FAIL rinc_guard: rinc=1 with rempty=%b grant=%b req=%b, required rempty=0 and a requesting one-hot owner",
                   rempty, grant, req);
        end
      end
      if (sb_en && dout_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: dout=%h id=%0d delivered, required no word", dout, dout_id);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.data || (e.chk_id && dout_id !== e.id)) begin
            n_fail++;
            $display("FAIL sb_word: got data=%h id=%0d, required data=%h id=%0d", dout, dout_id, e.data, e.id);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [1:0] id, input logic [7:0] data, input bit chk);
    wr_q.push_back(data);
    if (sb_en) exp_q.push_back('{id: id, data: data, chk_id: chk});
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || wr_q.size() != 0) && k < 100) begin
      @(negedge rclk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
    end
  endtask

  // Records rinc per cycle starting at the first rinc, plus dout_valid count.
  task automatic capture_rinc(input int n, output logic [15:0] pat, output int dv);
    int k;
    pat = '0;
    dv  = 0;
    k   = 0;
    @(negedge rclk);
    while (rinc !== 1'b1 && k < 40) begin
      @(negedge rclk);
      k++;
    end
    if (rinc === 1'b1) begin
      for (int i = 0; i < n; i++) begin
        pat[i] = rinc;
        dv += int'(dout_valid === 1'b1);
        @(negedge rclk);
      end
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    req    = 4'b0;
    repeat (3) step();
    n_tests += 5;
    if (grant !== 4'b0)      begin n_fail++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    if (rinc !== 1'b0)       begin n_fail++; $display("FAIL reset_rinc: got %b, required 0", rinc); end
    if (dout !== 8'h00)      begin n_fail++; $display("FAIL reset_dout: got %h, required 00", dout); end
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b, required 0", dout_valid); end
    if (dout_id !== 2'd0)    begin n_fail++; $display("FAIL reset_dout_id: got %0d, required 0", dout_id); end
`ifdef FIFO_RD_ARB_STATS_EN
    n_tests += 2;
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d, required 0", word_cnt); end
    if (starve !== 4'b0)    begin n_fail++; $display("FAIL reset_starve: got %b, required 0000", starve); end
`endif
    rrst_n = 1'b1;
    step();
  endtask

`ifdef FIFO_RD_ARB_STATS_EN
  task automatic test_stats();
    step();
    req = 4'b1000;
    repeat (15) @(posedge rclk);
    #1;
    n_tests++;
    if (starve !== 4'b0000) begin n_fail++; $display("FAIL starve_early: got %b after 15 cycles, required 0000", starve); end
    @(posedge rclk);
    #1;
    n_tests++;
    if (starve !== 4'b1000) begin n_fail++; $display("FAIL starve_set: got %b after 16 cycles, required 1000", starve); end
    for (int i = 0; i < 10; i++) push_word(2'd3, 8'h60 + 8'(i), 1'b1);
    wait_drain("stats");
    repeat (3) step();
    n_tests += 2;
    if (word_cnt !== 16'd10) begin n_fail++; $display("FAIL word_cnt: got %0d, required 10", word_cnt); end
    if (starve !== 4'b0000)  begin n_fail++; $display("FAIL starve_clear: got %b, required 0000", starve); end
    req = 4'b0;
  endtask
`endif

  task automatic test_two_req();
    logic [15:0] pat;
    int          dv;
    step();
    req = 4'b0101;
    for (int i = 0; i < 8; i++) push_word((i < 4) ? 2'd0 : 2'd2, 8'h10 + 8'(i), 1'b1);
    capture_rinc(12, pat, dv);
    n_tests++;
    if (pat[11:0] !== 12'h1EF) begin n_fail++; $display("FAIL two_req_rinc: pattern %b, required 000111101111", pat[11:0]); end
    wait_drain("two_req");
    req = 4'b0;
  endtask

  task automatic test_single_req();
    logic [15:0] pat;
    int          dv;
    step();
    req = 4'b1000;
    push_word(2'd3, 8'h20, 1'b1);
    push_word(2'd3, 8'h21, 1'b1);
    capture_rinc(8, pat, dv);
    n_tests += 2;
    if (pat[7:0] !== 8'h03) begin n_fail++; $display("FAIL single_rinc: pattern %b, required 00000011", pat[7:0]); end
    if (dv !== 2)           begin n_fail++; $display("FAIL single_dv: got %0d valid words, required 2", dv); end
    wait_drain("single");
    // rr pointer wrapped to 0, so requester 0 wins over 3.
    step();
    req = 4'b1001;
    push_word(2'd0, 8'h30, 1'b1);
    push_word(2'd0, 8'h31, 1'b1);
    wait_drain("wrap");
    req = 4'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    int          dv;
    step();
    req = 4'b0001;
    for (int i = 0; i < 6; i++) push_word(2'd0, 8'h40 + 8'(i), 1'b1);
    capture_rinc(10, pat, dv);
    n_tests += 2;
    if (pat[9:0] !== 10'h06F) begin n_fail++; $display("FAIL b2b_rinc: pattern %b, required 0001101111", pat[9:0]); end
    if (dv !== 6)             begin n_fail++; $display("FAIL b2b_dv: got %0d valid words, required 6", dv); end
    wait_drain("b2b");
    req = 4'b0;
  endtask

  task automatic test_req_drop();
    int k;
    step();
    req = 4'b0110;
    push_word(2'd1, 8'h50, 1'b1);
    push_word(2'd1, 8'h51, 1'b1);
    for (int i = 2; i < 6; i++) push_word(2'd2, 8'h50 + 8'(i), 1'b1);
    k = 0;
    @(negedge rclk);
    while (rinc !== 1'b1 && k < 40) begin
      @(negedge rclk);
      k++;
    end
    @(posedge rclk);
    @(posedge rclk);
    #1;
    req = 4'b0100;
    #1;
    n_tests++;
    if (rinc !== 1'b0) begin n_fail++; $display("FAIL drop_rinc: got %b after req drop, required 0", rinc); end
    wait_drain("req_drop");
    req = 4'b0;
  endtask

  task automatic test_random();
    step();
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) push_word(2'd0, 8'($urandom_range(0, 255)), 1'b0);
      step();
    end
    req = 4'hF;
    wait_drain("random");
    req = 4'b0;
  endtask

  task automatic test_reset_mid_burst();
    int k;
    step();
    sb_en = 1'b0;
    req   = 4'b0001;
    for (int i = 0; i < 8; i++) push_word(2'd0, 8'h70 + 8'(i), 1'b0);
    k = 0;
    @(negedge rclk);
    while (rinc !== 1'b1 && k < 40) begin
      @(negedge rclk);
      k++;
    end
    @(posedge rclk);
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    #1;
    n_tests += 3;
    if (grant !== 4'b0)      begin n_fail++; $display("FAIL async_grant: got %b, required 0000", grant); end
    if (rinc !== 1'b0)       begin n_fail++; $display("FAIL async_rinc: got %b, required 0", rinc); end
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL async_dout_valid: got %b, required 0", dout_valid); end
    repeat (2) step();
    req    = 4'b0;
    rrst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
`ifdef FIFO_RD_ARB_STATS_EN
    test_stats();
`endif
    test_two_req();
    test_single_req();
    test_back_to_back();
    test_req_drop();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
